// File: rtl/brew_order_scheduler_if.sv
// Order and brewer handshake bundle for brew_order_scheduler.
// master = requesters + brewer side, slave = scheduler side.
interface brew_order_scheduler_if;
  logic       p0_valid;
  logic [1:0] p0_type;
  logic       p0_ready;
  logic       p1_valid;
  logic [1:0] p1_type;
  logic       p1_ready;
  logic       brew_ok;
  logic [1:0] brew_c_type;
  logic       brew_busy;

  modport master (
    output p0_valid, p0_type, p1_valid, p1_type, brew_busy,
    input  p0_ready, p1_ready, brew_ok, brew_c_type
  );

  modport slave (
    input  p0_valid, p0_type, p1_valid, p1_type, brew_busy,
    output p0_ready, p1_ready, brew_ok, brew_c_type
  );
endinterface

// File: rtl/brew_order_scheduler.sv
// Two-port round-robin order FIFO feeding a single brewer with start timeout and inter-brew gap.
// Optional served-brew counter enabled by defining ORDER_STATS_EN.
//
// state      | meaning
// S_IDLE     | wait for a queued order, pop it into cur_type
// S_ISSUE    | one-cycle brew_ok pulse to the brewer
// S_WAIT_START | wait for brew_busy, time out after START_TIMEOUT cycles
// S_BREWING  | brewer active
// S_GAP      | GAP_CYCLES idle cycles before the next dispatch
module brew_order_scheduler #(
  parameter int FIFO_DEPTH    = 4,
  parameter int GAP_CYCLES    = 2,
  parameter int START_TIMEOUT = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  brew_order_scheduler_if.slave       bus,
  output logic                        sched_busy_o,
  output logic [$clog2(FIFO_DEPTH):0] q_count_o,
  output logic                        err_timeout_o,
  output logic [7:0]                  served_count_o
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int TMAX = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_START,
    S_BREWING,
    S_GAP
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    cur_type_q, cur_type_d;
  logic          err_q, err_d;

  logic [1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          rr_q, rr_d;

  logic          full, grant0, grant1, push, pop;
  logic [1:0]    push_type;

  // Full uses the pre-edge count, so a same-cycle pop never makes room for a push.
  assign full   = (count_q == CW'(FIFO_DEPTH));
  assign grant0 = bus.p0_valid && (!bus.p1_valid || !rr_q);
  assign grant1 = bus.p1_valid && (!bus.p0_valid || rr_q);

  assign bus.p0_ready = grant0 && !full && !reset;
  assign bus.p1_ready = grant1 && !full && !reset;

  assign push      = (grant0 || grant1) && !full && !reset;
  assign push_type = grant1 ? bus.p1_type : bus.p0_type;
  assign pop       = (state_q == S_IDLE) && (count_q != '0);
  assign rr_d      = push ? grant0 : rr_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_type;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_q     <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    cur_type_d = cur_type_q;
    err_d      = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          cur_type_d = mem_q[rd_ptr_q];
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = TW'(START_TIMEOUT - 1);
        state_d = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (bus.brew_busy) begin
          state_d = S_BREWING;
        end else if (timer_q == '0) begin
          err_d   = 1'b1;
          timer_d = TW'(GAP_CYCLES - 1);
          state_d = S_GAP;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_BREWING: begin
        if (!bus.brew_busy) begin
          timer_d = TW'(GAP_CYCLES - 1);
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (timer_q == '0) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      cur_type_q <= 2'b00;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      cur_type_q <= cur_type_d;
      err_q      <= err_d;
    end
  end

  assign bus.brew_ok     = (state_q == S_ISSUE);
  assign bus.brew_c_type = cur_type_q;
  assign sched_busy_o    = (state_q != S_IDLE) || (count_q != '0);
  assign q_count_o       = count_q;
  assign err_timeout_o   = err_q;

`ifdef ORDER_STATS_EN
  logic       brew_done;
  logic [7:0] served_q;

  // Timed-out orders leave through WAIT_START, so only real brews are counted.
  assign brew_done = (state_q == S_BREWING) && !bus.brew_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      served_q <= 8'd0;
    end else if (brew_done && (served_q != 8'hFF)) begin
      served_q <= served_q + 8'd1;
    end
  end

  assign served_count_o = served_q;
`else
  assign served_count_o = 8'd0;
`endif

endmodule

// File: tb/tb_brew_order_scheduler.sv
// Scoreboard bench for brew_order_scheduler: directed orders, brewer model, decoupled dispatch monitor.
module tb_brew_order_scheduler;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  brew_order_scheduler_if bus ();

  logic       sched_busy;
  logic [2:0] q_count;
  logic       err_timeout;
  logic [7:0] served_count;

  brew_order_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .sched_busy_o   (sched_busy),
    .q_count_o      (q_count),
    .err_timeout_o  (err_timeout),
    .served_count_o (served_count)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [1:0] exp_q [$];

  int brew_len = 4;
  bit brewer_dead = 1'b0;
  int b_dly = 0;
  int b_rem = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_served(input int n);
    int r = n;
`ifdef ORDER_STATS_EN
    if (r > 255) r = 255;
`else
    r = 0;
`endif
    return r;
  endfunction

  // Brewer: raises busy two cycles after sampling brew_ok, holds it brew_len cycles.
  initial begin
    bus.brew_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        bus.brew_busy = 1'b0;
        b_dly = 0;
        b_rem = 0;
      end else if (b_rem > 0) begin
        b_rem--;
        if (b_rem == 0) bus.brew_busy = 1'b0;
      end else if (b_dly > 0) begin
        b_dly--;
        if (b_dly == 0) begin
          bus.brew_busy = 1'b1;
          b_rem = brew_len;
        end
      end else if (bus.brew_ok && !brewer_dead) begin
        b_dly = 2;
      end
    end
  end

  // Monitor: pops the scoreboard on each dispatch and checks type stability while brewing.
  initial begin
    logic       prev_ok;
    logic [1:0] cur_exp;
    bit         cur_valid;
    prev_ok = 1'b0;
    cur_exp = 2'b00;
    cur_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cur_valid = 1'b0;
      end else begin
        if (bus.brew_ok) begin
          check("brew_ok_single_pulse", int'(prev_ok), 0);
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_dispatch: brew_ok with type %0d, none expected", bus.brew_c_type);
          end else begin
            cur_exp = exp_q.pop_front();
            cur_valid = 1'b1;
            check("dispatch_type", int'(bus.brew_c_type), int'(cur_exp));
          end
        end
        if (bus.brew_busy && cur_valid)
          check("type_stable_while_brewing", int'(bus.brew_c_type), int'(cur_exp));
      end
      prev_ok = bus.brew_ok;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.p0_valid = 1'b0;
    bus.p1_valid = 1'b0;
    @(negedge clk);
    #1;
    check("rst_q_count", int'(q_count), 0);
    check("rst_sched_busy", int'(sched_busy), 0);
    check("rst_err_timeout", int'(err_timeout), 0);
    check("rst_served_count", int'(served_count), 0);
    check("rst_brew_ok", int'(bus.brew_ok), 0);
    check("rst_brew_c_type", int'(bus.brew_c_type), 0);
    check("rst_ready", int'({bus.p0_ready, bus.p1_ready}), 0);
    exp_q.delete();
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic send(input int p, input logic [1:0] t);
    int n;
    logic rdy;
    n = 0;
    @(negedge clk);
    if (p == 0) begin bus.p0_valid = 1'b1; bus.p0_type = t; end
    else        begin bus.p1_valid = 1'b1; bus.p1_type = t; end
    #1;
    rdy = (p == 0) ? bus.p0_ready : bus.p1_ready;
    while (!rdy && n < 300) begin
      @(negedge clk);
      #1;
      n++;
      rdy = (p == 0) ? bus.p0_ready : bus.p1_ready;
    end
    check("send_accepted", int'(rdy), 1);
    if (rdy) exp_q.push_back(t);
    @(negedge clk);
    if (p == 0) bus.p0_valid = 1'b0;
    else        bus.p1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    #1;
    while ((sched_busy || bus.brew_busy) && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("idle_reached", int'(sched_busy || bus.brew_busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0_t [8] = '{1, 0, 1, 0, 1, 0, 0, 0};
    int r1_t [8] = '{0, 1, 0, 1, 0, 0, 0, 0};
    int qc_t [8] = '{0, 1, 1, 2, 3, 4, 4, 4};
    int n;
    bit seen;
    logic [2:0] pq;
    logic pr;

    reset = 1'b1;
    bus.p0_valid = 1'b0;
    bus.p0_type  = 2'b00;
    bus.p1_valid = 1'b0;
    bus.p1_type  = 2'b00;

    // Single order from idle: 2-cycle accept-to-start latency.
    do_reset();
    @(negedge clk);
    bus.p0_valid = 1'b1;
    bus.p0_type  = 2'b01;
    #1;
    check("t1_p0_ready", int'(bus.p0_ready), 1);
    check("t1_p1_ready", int'(bus.p1_ready), 0);
    exp_q.push_back(2'b01);
    @(negedge clk);
    bus.p0_valid = 1'b0;
    #1;
    check("t1_q_count_after_accept", int'(q_count), 1);
    check("t1_brew_ok_early", int'(bus.brew_ok), 0);
    @(negedge clk);
    #1;
    check("t1_brew_ok_latency", int'(bus.brew_ok), 1);
    check("t1_q_count_after_pop", int'(q_count), 0);
    @(negedge clk);
    #1;
    check("t1_brew_ok_fall", int'(bus.brew_ok), 0);
    wait_idle();
    check("t1_type_held", int'(bus.brew_c_type), 1);
    check("t1_served", int'(served_count), exp_served(1));

    // Both ports valid continuously: round-robin fill up to full.
    do_reset();
    brew_len = 20;
    @(negedge clk);
    bus.p0_valid = 1'b1; bus.p0_type = 2'b00;
    bus.p1_valid = 1'b1; bus.p1_type = 2'b11;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("t2_p0_ready", int'(bus.p0_ready), r0_t[i]);
      check("t2_p1_ready", int'(bus.p1_ready), r1_t[i]);
      check("t2_q_count", int'(q_count), qc_t[i]);
      if (r0_t[i] == 1) exp_q.push_back(2'b00);
      if (r1_t[i] == 1) exp_q.push_back(2'b11);
      @(negedge clk);
    end
    bus.p0_valid = 1'b0;
    bus.p1_valid = 1'b0;
    wait_idle();
    check("t2_served", int'(served_count), exp_served(5));

    // Full FIFO with same-cycle pop: push refused, accepted next cycle.
    do_reset();
    brew_len = 12;
    send(0, 2'b01);
    send(0, 2'b00);
    send(0, 2'b11);
    send(0, 2'b01);
    send(0, 2'b00);
    #1;
    check("t3_full_count", int'(q_count), 4);
    bus.p0_valid = 1'b1;
    bus.p0_type  = 2'b11;
    #1;
    pq = q_count;
    pr = bus.p0_ready;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      #1;
      n++;
      if (q_count == 3'd3) seen = 1'b1;
      else begin pq = q_count; pr = bus.p0_ready; end
    end
    check("t3_pop_seen", int'(seen), 1);
    check("t3_count_before_pop", int'(pq), 4);
    check("t3_ready_refused_at_pop", int'(pr), 0);
    check("t3_ready_after_pop", int'(bus.p0_ready), 1);
    if (bus.p0_ready) exp_q.push_back(2'b11);
    @(negedge clk);
    bus.p0_valid = 1'b0;
    #1;
    check("t3_count_refilled", int'(q_count), 4);
    wait_idle();
    check("t3_served", int'(served_count), exp_served(6));

    // Brewer never starts: timeout, drop, next order after the gap.
    do_reset();
    brewer_dead = 1'b1;
    brew_len = 3;
    @(negedge clk);
    bus.p0_valid = 1'b1; bus.p0_type = 2'b01;
    bus.p1_valid = 1'b1; bus.p1_type = 2'b11;
    #1;
    check("t4_p0_first", int'(bus.p0_ready), 1);
    exp_q.push_back(2'b01);
    @(negedge clk);
    bus.p0_valid = 1'b0;
    #1;
    check("t4_p1_second", int'(bus.p1_ready), 1);
    exp_q.push_back(2'b11);
    @(negedge clk);
    bus.p1_valid = 1'b0;
    #1;
    check("t4_first_issue", int'(bus.brew_ok), 1);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      #1;
      check("t4_err_not_yet", int'(err_timeout), 0);
    end
    @(negedge clk);
    #1;
    check("t4_err_set", int'(err_timeout), 1);
    brewer_dead = 1'b0;
    @(negedge clk);
    #1;
    check("t4_gap_no_issue", int'(bus.brew_ok), 0);
    @(negedge clk);
    #1;
    check("t4_idle_no_issue", int'(bus.brew_ok), 0);
    @(negedge clk);
    #1;
    check("t4_second_issue", int'(bus.brew_ok), 1);
    wait_idle();
    check("t4_err_sticky", int'(err_timeout), 1);
    check("t4_served", int'(served_count), exp_served(1));

    // Reset while brewing with two orders queued.
    do_reset();
    brew_len = 20;
    send(0, 2'b11);
    send(1, 2'b01);
    send(0, 2'b00);
    n = 0;
    #1;
    while (!(bus.brew_busy && q_count == 3'd2) && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t5_brewing_with_two_queued", int'(bus.brew_busy && q_count == 3'd2), 1);
    @(negedge clk);
    do_reset();
    check("t5_err_after_reset", int'(err_timeout), 0);
    send(1, 2'b01);
    wait_idle();
    check("t5_q_count_end", int'(q_count), 0);
    check("t5_served", int'(served_count), exp_served(1));

`ifdef ORDER_STATS_EN
    // Served counter saturation.
    do_reset();
    brew_len = 1;
    for (int i = 0; i < 260; i++) begin
      send(i % 2, (i % 2 == 1) ? 2'b11 : 2'b01);
    end
    wait_idle();
    check("t6_served_saturated", int'(served_count), 255);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/brew_order_scheduler.md
# brew_order_scheduler

Order scheduler in front of the coffee-brewing sequencer. It accepts drink orders from two requesters (front panel, remote port) through valid/ready handshakes and buffers them in a shared FIFO. It dispatches one order at a time to the single brewer, holding the drink type stable for the whole brew. It enforces an idle gap between brews and flags a brewer that never starts.

## Interface
- FIFO_DEPTH, 4: order queue depth; power of two, ≥2.
- GAP_CYCLES, 2: idle cycles inserted after each brew before the next dispatch; ≥1.
- START_TIMEOUT, 8: cycles to wait for brew_busy after issuing an order; ≥4.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- p0_valid  in  1  port 0 order request.
- p0_type  in  2  port 0 drink type (00 plain, 01 with milk, 11 milk+choco; 10 treated as milk).
- p0_ready  out  1  port 0 order accepted this cycle if p0_valid.
- p1_valid, p1_type, p1_ready: same as port 0, for port 1.
- brew_ok  out  1  one-cycle start pulse to brewer.
- brew_c_type  out  2  drink type to brewer; stable for the whole brew.
- brew_busy  in  1  brewer active; driven high whenever any ingredient output is nonzero.
- sched_busy  out  1  queue non-empty or dispatcher not IDLE.
- q_count  out  clog2(FIFO_DEPTH)+1  orders queued.
- err_timeout  out  1  sticky: brewer failed to start; cleared only by reset.
- served_count  out  8  completed brews (see Configuration).

## Operation
- Handshake: a transfer occurs on a rising edge with valid && ready. A requester holds valid and type stable until the transfer. Ready is combinational from valid inputs, FIFO count and the RR pointer.
- Arbitration: at most one push per cycle. If only one port is valid, it is granted. If both are valid, the port not granted last time wins (round-robin pointer; reset favours port 0). The pointer updates only on a transfer.
- pN_ready = granted && !full. Full is evaluated on the pre-edge count; a same-cycle pop does not free space for a push (no bypass).
- FIFO: wrap-around read/write pointers plus count. Push and pop in the same cycle leave the count unchanged.
- Dispatcher states and transitions:
  - IDLE: if count>0, pop head into cur_type and go to ISSUE.
  - ISSUE: brew_ok=1; go to WAIT_START and clear the timer.
  - WAIT_START: if brew_busy, go to BREWING. Otherwise increment the timer; when it reaches START_TIMEOUT, set err_timeout, drop the order and go to GAP.
  - BREWING: when !brew_busy, go to GAP.
  - GAP: count GAP_CYCLES cycles, then go to IDLE.
- brew_ok is a Moore output of the ISSUE state. brew_c_type is the cur_type register, loaded at the pop and held through GAP and IDLE until the next pop.
- sched_busy = (state != IDLE) || (count != 0).
- Reset value of every output is 0. Reset empties the FIFO, returns the dispatcher to IDLE, resets the RR pointer to 0, and clears err_timeout and served_count. A reset mid-brew abandons the order; the brewer is reset by the same signal.

## Timing
- Order accepted at edge T: q_count increments at T+1, the pop happens at edge T+1, and brew_ok is high during cycle T+1→T+2 (2-cycle accept-to-start latency from an empty, idle scheduler).
- The brewer raises brew_busy 2 cycles after sampling brew_ok, well inside START_TIMEOUT.
- After brew_busy falls, the next brew_ok follows no sooner than GAP_CYCLES+2 cycles.
- Continuous throughput is limited by brew length. The FIFO absorbs up to FIFO_DEPTH orders while brewing.

## Configuration
- ORDER_STATS_EN defined: served_count increments on each BREWING→GAP transition and saturates at 255. Timed-out orders are not counted.
- ORDER_STATS_EN undefined: no counter logic; served_count is tied to 0.

## Test plan
- Single order, p0 type 01, idle: p0_ready=1 at once; brew_ok pulses exactly 1 cycle 2 cycles later; brew_c_type=01 until busy falls; served_count=1 (stats on).
- Both ports valid continuously, p0 type 00, p1 type 11: accepts alternate p0,p1,p0,p1 until q_count=4; both readys low while full; brews dispatched in acceptance order.
- Fill FIFO to 4 while BREWING, then pop and push in the same cycle: push refused that cycle, accepted next; q_count sequence 4→3→4.
- brew_busy held 0 after brew_ok: err_timeout rises after 8 cycles, the order is dropped, the next queued order issues after the GAP, and err_timeout stays 1.
- Reset asserted during BREWING with 2 orders queued: next cycle all outputs 0, q_count=0, state IDLE; new order served normally.
- Stats saturation (ORDER_STATS_EN): 260 short brews leave served_count=255. Without the macro, served_count stays 0.
